pll_lock_reset_ctrl: RTL

- Consumer-side controller for the core PLL, clocked from the 50 MHz reference clock.
- Drives the PLL reset and synchronises and debounces the PLL lock indicator.
- Holds the core's system reset until lock has been stable for a programmable time.
- Detects loss of lock or lock timeout and automatically re-reset the PLL; reports status and a relock counter to the OSD/debug path.

---
 rtl/pll_ctrl_pkg.sv | 25 ++
 rtl/sync_ff_chain.sv | 33 +++
 rtl/pll_lock_reset_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared types and constants for the PLL lock/reset controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

  // Width of the controller state encoding, as seen on state_o
  localparam int STATE_W  = 3;

  // Width of the saturating lock-loss counter
  localparam int RELOCK_W = 8;

  // Controller states; encodings 5-7 are unused and recover to PLL_RST
  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } pll_state_e;

endpackage : pll_ctrl_pkg
`default_nettype wire

// File: rtl/sync_ff_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff_chain
// Description : Async-reset flop chain bringing asynchronous status inputs
//               into the clk domain. Resets to 0. STAGES must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Stage 0 captures the raw input; the last stage is the synchronised output
  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // Shift the input through the chain every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule : sync_ff_chain
`default_nettype wire

// File: rtl/pll_lock_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_ctrl
// Description : Drives the PLL reset, synchronises the PLL lock indicator,
//               holds the core reset until lock has been stable, and
//               re-resets the PLL on lock loss, lock timeout or soft request.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                soft_rst_req,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                ready,
  output logic [STATE_W-1:0]  state_o,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic                timeout_err
);

  // Terminal counts of the shared cycle counter for each timed state
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic                lock_s;
  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                timeout_q, timeout_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                ready_q, ready_d;

  // All FSM decisions are taken on the synchronised lock only
  sync_ff_chain #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  // State, shared counter and sticky status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      relock_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state decode; soft request outranks lock events, lock outranks timeout
  always_comb begin
    state_d   = state_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;
    case (state_q)
      PLL_RST: begin
        // soft_rst_req is ignored here so the reset pulse is never stretched
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (soft_rst_req) begin
          state_d = PLL_RST;
        end else if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          timeout_d = 1'b1;
        end
      end
      STABLE: begin
        // A drop during bring-up just restarts the wait; not a relock event
        if (soft_rst_req) begin
          state_d = PLL_RST;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (soft_rst_req) begin
          state_d = PLL_RST;
        end else if (!lock_s) begin
          state_d = LOST;
          if (relock_q != '1) begin
            relock_d = relock_q + RELOCK_W'(1);
          end
        end
      end
      LOST: begin
        state_d = PLL_RST;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase
    // The counter restarts on every transition and free-runs otherwise
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output decode from the next state so registered outputs align with state_o
  always_comb begin
    pll_rst_d   = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  // Registered outputs; reset values apply immediately on rst_n assertion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign state_o     = state_q;
  assign relock_cnt  = relock_q;
  assign timeout_err = timeout_q;

endmodule : pll_lock_reset_ctrl
`default_nettype wire
